mtr_duty_ctrl: RTL and testbench

Sequences duty-cycle updates for the left and right motor PWM channels. Accepts signed speed targets over a valid/ready handshake, slews each channel's actual speed toward its target once per PWM period, and presents period-aligned 11-bit duties to the two PWM instances. A brake input forces a fast ramp to zero speed. Sits between the motion/PID logic and the PWM generators.

---
 rtl/mtr_pkg.sv | 33 +++
 rtl/duty_slew.sv | 39 +++
 rtl/mtr_duty_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mtr_duty_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor duty-cycle controller.
package mtr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      HOLD  = 2'd2,
      BRAKE = 2'd3
   } mtr_st_t;

   localparam int                DUTY_W   = 11;
   localparam logic [DUTY_W-1:0] DUTY_MID = 11'h400;
   localparam int                SPD_MAX  = 1023;
   localparam logic [DUTY_W-1:0] CNT_LAST = 11'h7FF;

   // Clamp a 12-bit signed speed request into the symmetric +/-SPD_MAX range.
   function automatic logic signed [DUTY_W-1:0] sat_spd(input logic signed [11:0] v);
      logic signed [11:0]       lim;
      logic signed [11:0]       neg_lim;
      logic signed [DUTY_W-1:0] r;
      lim     = 12'(SPD_MAX);
      neg_lim = -lim;
      if (v > lim) begin
         r = lim[DUTY_W-1:0];
      end else if (v < neg_lim) begin
         r = neg_lim[DUTY_W-1:0];
      end else begin
         r = v[DUTY_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/duty_slew.sv
// Per-channel slew unit: moves the actual speed one step toward the target.
// MTR_RAMP_EN defined   : bounded step of 'step' per update.
// MTR_RAMP_EN undefined : the actual jumps straight to the target.
module duty_slew
   import mtr_pkg::*;
(
   input  logic signed [DUTY_W-1:0] tgt,
   input  logic signed [DUTY_W-1:0] act,
   input  logic        [9:0]        step,
   output logic signed [DUTY_W-1:0] act_nxt,
   output logic                     at_tgt
);

`ifdef MTR_RAMP_EN
   logic signed [11:0] diff;
   logic        [11:0] mag;

   // Snap to target when within one step, otherwise move by exactly one step.
   always_comb begin
      diff = {tgt[DUTY_W-1], tgt} - {act[DUTY_W-1], act};
      mag  = diff[11] ? 12'(-diff) : diff;
      if (mag <= {2'b00, step}) begin
         act_nxt = tgt;
      end else if (diff[11]) begin
         act_nxt = act - $signed({1'b0, step});
      end else begin
         act_nxt = act + $signed({1'b0, step});
      end
   end
`else
   logic unused_step;

   assign unused_step = ^step;
   assign act_nxt     = tgt;
`endif

   assign at_tgt = (act_nxt == tgt);

endmodule

// File: rtl/mtr_duty_ctrl.sv
// Left/right motor duty sequencer: target handshake, per-period slewing,
// brake fast-ramp and period-aligned duty outputs.
// Slew limiting is enabled by MTR_RAMP_EN (see duty_slew).
//
// state | meaning
// IDLE  | targets and actuals at zero, waiting for a nonzero target pair
// RAMP  | actuals slewing toward targets at each period boundary
// HOLD  | actuals equal targets, duties constant
// BRAKE | targets forced to zero, fast slew; spd_rdy low
module mtr_duty_ctrl
   import mtr_pkg::*;
#(
   parameter int unsigned STEP     = 16,
   parameter int unsigned BRK_MULT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [11:0]       lft_spd,
   input  logic signed [11:0]       rght_spd,
   input  logic                     spd_vld,
   output logic                     spd_rdy,
   input  logic                     brk,
   output logic        [DUTY_W-1:0] lft_duty,
   output logic        [DUTY_W-1:0] rght_duty,
   output logic                     duty_upd,
   output logic                     prd_strt,
   output logic                     settled
);

   localparam logic [9:0] STEP_NRM = 10'(STEP);
   localparam logic [9:0] STEP_BRK = 10'(STEP * BRK_MULT);

   mtr_st_t                  state_q, state_d;
   logic        [DUTY_W-1:0] cnt_q, cnt_d;
   logic signed [DUTY_W-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
   logic signed [DUTY_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
   logic                     settled_q, settled_d;
   logic                     duty_upd_q, duty_upd_d;
   logic                     prd_strt_q, prd_strt_d;

   logic signed [DUTY_W-1:0] act_l_nxt, act_r_nxt;
   logic signed [DUTY_W-1:0] sat_l, sat_r;
   logic                     at_l, at_r;
   logic [9:0]               step_s;
   logic                     bnd;
   logic                     hs;

   // Brake wins over a same-cycle handshake, so ready drops with the raw request.
   assign spd_rdy = (state_q != BRAKE) && !brk;
   assign hs      = spd_vld && spd_rdy;
   assign bnd     = (cnt_q == CNT_LAST);
   assign step_s  = (state_q == BRAKE) ? STEP_BRK : STEP_NRM;
   assign sat_l   = sat_spd(lft_spd);
   assign sat_r   = sat_spd(rght_spd);

   duty_slew u_slew_l (
      .tgt     (tgt_l_q),
      .act     (act_l_q),
      .step    (step_s),
      .act_nxt (act_l_nxt),
      .at_tgt  (at_l)
   );

   duty_slew u_slew_r (
      .tgt     (tgt_r_q),
      .act     (act_r_q),
      .step    (step_s),
      .act_nxt (act_r_nxt),
      .at_tgt  (at_r)
   );

   // Next-state, target capture and boundary-aligned actual update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      prd_strt_d = bnd;
      tgt_l_d    = tgt_l_q;
      tgt_r_d    = tgt_r_q;
      act_l_d    = act_l_q;
      act_r_d    = act_r_q;
      duty_upd_d = bnd && ((act_l_nxt != act_l_q) || (act_r_nxt != act_r_q));

      // Boundary update always uses the targets held before this cycle's handshake.
      if (bnd) begin
         act_l_d = act_l_nxt;
         act_r_d = act_r_nxt;
      end

      if (brk) begin
         state_d = BRAKE;
         tgt_l_d = '0;
         tgt_r_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hs) begin
                  tgt_l_d = sat_l;
                  tgt_r_d = sat_r;
                  if ((sat_l != '0) || (sat_r != '0)) state_d = RAMP;
               end
            end
            RAMP: begin
               if (hs) begin
                  tgt_l_d = sat_l;
                  tgt_r_d = sat_r;
               end else if (bnd && at_l && at_r) begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (hs) begin
                  tgt_l_d = sat_l;
                  tgt_r_d = sat_r;
                  if ((sat_l != act_l_q) || (sat_r != act_r_q)) state_d = RAMP;
               end
            end
            BRAKE: begin
               tgt_l_d = '0;
               tgt_r_d = '0;
               if ((act_l_q == '0) && (act_r_q == '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      settled_d = (act_l_d == tgt_l_d) && (act_r_d == tgt_r_d);
   end

   // Controller registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tgt_l_q    <= '0;
         tgt_r_q    <= '0;
         act_l_q    <= '0;
         act_r_q    <= '0;
         settled_q  <= 1'b1;
         duty_upd_q <= 1'b0;
         prd_strt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tgt_l_q    <= tgt_l_d;
         tgt_r_q    <= tgt_r_d;
         act_l_q    <= act_l_d;
         act_r_q    <= act_r_d;
         settled_q  <= settled_d;
         duty_upd_q <= duty_upd_d;
         prd_strt_q <= prd_strt_d;
      end
   end

   // Offset-binary duty straight from the actual registers, so reset lands on mid-scale.
   assign lft_duty  = DUTY_MID + $unsigned(act_l_q);
   assign rght_duty = DUTY_MID + $unsigned(act_r_q);
   assign duty_upd  = duty_upd_q;
   assign prd_strt  = prd_strt_q;
   assign settled   = settled_q;

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Directed bench for mtr_duty_ctrl (STEP=16, BRK_MULT=4).
// Expected duties follow the slewed sequence when MTR_RAMP_EN is defined,
// and the direct-jump sequence otherwise.
module tb_mtr_duty_ctrl;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [11:0] lft_spd, rght_spd;
   logic               spd_vld, spd_rdy, brk;
   logic [10:0]        lft_duty, rght_duty;
   logic               duty_upd, prd_strt, settled;

   int n_cmp = 0;
   int n_mis = 0;

`ifdef MTR_RAMP_EN
   int l2[7] = '{32'h410, 32'h420, 32'h430, 32'h440, 32'h450, 32'h460, 32'h464};
   int r2[7] = '{32'h3F0, 32'h3E0, 32'h3D8, 32'h3D8, 32'h3D8, 32'h3D8, 32'h3D8};
   int s2[7] = '{0, 0, 0, 0, 0, 0, 1};
   int l3[4] = '{32'h474, 32'h484, 32'h494, 32'h4A4};
   int r3[4] = '{32'h3C8, 32'h3B8, 32'h3A8, 32'h398};
   int s3[4] = '{0, 0, 0, 0};
   int l4[3] = '{32'h464, 32'h424, 32'h400};
   int r4[3] = '{32'h3D8, 32'h400, 32'h400};
   int l5    = 32'h410;
`else
   int l2[7] = '{32'h464, 32'h464, 32'h464, 32'h464, 32'h464, 32'h464, 32'h464};
   int r2[7] = '{32'h3D8, 32'h3D8, 32'h3D8, 32'h3D8, 32'h3D8, 32'h3D8, 32'h3D8};
   int s2[7] = '{1, 1, 1, 1, 1, 1, 1};
   int l3[4] = '{32'h7FF, 32'h7FF, 32'h7FF, 32'h7FF};
   int r3[4] = '{32'h001, 32'h001, 32'h001, 32'h001};
   int s3[4] = '{1, 1, 1, 1};
   int l4[3] = '{32'h400, 32'h400, 32'h400};
   int r4[3] = '{32'h400, 32'h400, 32'h400};
   int l5    = 32'h428;
`endif

   mtr_duty_ctrl #(.STEP(16), .BRK_MULT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lft_spd   (lft_spd),
      .rght_spd  (rght_spd),
      .spd_vld   (spd_vld),
      .spd_rdy   (spd_rdy),
      .brk       (brk),
      .lft_duty  (lft_duty),
      .rght_duty (rght_duty),
      .duty_upd  (duty_upd),
      .prd_strt  (prd_strt),
      .settled   (settled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Advance to the next negedge where prd_strt is high; ncyc = negedges taken.
   task automatic wait_prd(output int ncyc);
      ncyc = 0;
      do begin
         @(negedge clk);
         ncyc++;
      end while (!prd_strt && ncyc < 3000);
      if (!prd_strt) chk("prd_timeout", 0, 1);
   endtask

   task automatic chk_duty(input string tag, input int l, input int r);
      chk({tag, "_l"}, int'(lft_duty), l);
      chk({tag, "_r"}, int'(rght_duty), r);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nc;
      rst_n = 1'b0; lft_spd = '0; rght_spd = '0; spd_vld = 1'b0; brk = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      chk_duty("rst", 32'h400, 32'h400);
      chk("rst_rdy", int'(spd_rdy), 1);
      chk("rst_upd", int'(duty_upd), 0);
      chk("rst_prd", int'(prd_strt), 0);
      chk("rst_settled", int'(settled), 1);
      rst_n = 1'b1;

      // Idle periods
      wait_prd(nc);
      chk("first_prd", nc, 2048);
      for (int i = 0; i < 2; i++) begin
         wait_prd(nc);
         chk($sformatf("prd_int%0d", i), nc, 2048);
         chk_duty($sformatf("idle%0d", i), 32'h400, 32'h400);
         chk($sformatf("idle_settled%0d", i), int'(settled), 1);
         chk($sformatf("idle_upd%0d", i), int'(duty_upd), 0);
      end

      // Ramp to 100 / -40
      lft_spd = 12'sd100; rght_spd = -12'sd40; spd_vld = 1'b1;
      chk("t2_rdy", int'(spd_rdy), 1);
      @(negedge clk);
      spd_vld = 1'b0;
      chk("t2_prd_pulse", int'(prd_strt), 0);
      chk("t2_unsettled", int'(settled), 0);
      for (int i = 0; i < 7; i++) begin
         wait_prd(nc);
         chk_duty($sformatf("t2_b%0d", i), l2[i], r2[i]);
         chk($sformatf("t2_settled%0d", i), int'(settled), s2[i]);
         if (i == 0) chk("t2_upd0", int'(duty_upd), 1);
      end
      wait_prd(nc);
      chk_duty("t2_hold", 32'h464, 32'h3D8);
      chk("t2_hold_upd", int'(duty_upd), 0);

      // Saturating targets 2000 / -2048
      lft_spd = 12'sd2000; rght_spd = -12'sd2048; spd_vld = 1'b1;
      @(negedge clk);
      spd_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_prd(nc);
         chk_duty($sformatf("t3_b%0d", i), l3[i], r3[i]);
         chk($sformatf("t3_settled%0d", i), int'(settled), s3[i]);
      end

      // Brake with a competing handshake held high
      brk = 1'b1; spd_vld = 1'b1; lft_spd = 12'sd300; rght_spd = 12'sd300;
      #1;
      chk("t4_rdy_now", int'(spd_rdy), 0);
      @(negedge clk);
      chk("t4_rdy_next", int'(spd_rdy), 0);
      for (int i = 0; i < 3; i++) begin
         wait_prd(nc);
         chk_duty($sformatf("t4_b%0d", i), l4[i], r4[i]);
         chk($sformatf("t4_rdy%0d", i), int'(spd_rdy), 0);
      end
      repeat (10) @(negedge clk);
      chk_duty("t4_zero", 32'h400, 32'h400);
      chk("t4_rdy_held", int'(spd_rdy), 0);
      spd_vld = 1'b0; brk = 1'b0;
      @(negedge clk);
      chk("t4_rdy_idle", int'(spd_rdy), 1);
      chk("t4_settled", int'(settled), 1);

      // Handshake exactly on the boundary cycle
      wait_prd(nc);
      repeat (2047) @(negedge clk);
      lft_spd = 12'sd40; rght_spd = -12'sd8; spd_vld = 1'b1;
      chk("t5_rdy", int'(spd_rdy), 1);
      wait_prd(nc);
      spd_vld = 1'b0;
      chk("t5_on_bnd", nc, 1);
      chk_duty("t5_old", 32'h400, 32'h400);
      chk("t5_old_upd", int'(duty_upd), 0);
      wait_prd(nc);
      chk_duty("t5_new", l5, 32'h3F8);
      chk("t5_new_upd", int'(duty_upd), 1);

      // Asynchronous reset mid-operation
      repeat (100) @(negedge clk);
      chk_duty("t6_pre", l5, 32'h3F8);
      #2 rst_n = 1'b0;
      #1;
      chk_duty("t6_async", 32'h400, 32'h400);
      chk("t6_settled", int'(settled), 1);
      chk("t6_rdy", int'(spd_rdy), 1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_prd(nc);
      chk("t6_restart", nc, 2048);
      chk_duty("t6_after", 32'h400, 32'h400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
